// File: rtl/pgm_memory_pkg.sv
// Shared types and constants for the instruction memory and its bootloader.
package pgm_memory_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit,
        StRun
    } state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ram_1r1w.sv
// Simple dual-port RAM: one synchronous read port, one synchronous write port, array not reset.
module ram_1r1w #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pgm_memory.sv
// Instruction memory with a byte-serial bootloader; fetches return NOPs until a load session ends.
module pgm_memory
    import pgm_memory_pkg::*;
#(
    parameter int unsigned DATA_IBUS_WIDTH = 32,
    parameter int unsigned ADDR_IBUS_WIDTH = 32,
    parameter int unsigned DEPTH           = 1024
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic [ADDR_IBUS_WIDTH-1:0] i_PgmAddr,
    output logic [DATA_IBUS_WIDTH-1:0] o_PgmInst,
    output logic                       o_PgmValid,
    input  logic                       i_LdStart,
    input  logic                       i_LdValid,
    input  logic [7:0]                 i_LdData,
    output logic                       o_LdReady,
    input  logic                       i_LdDone,
    output logic                       o_Loading,
    output logic [$clog2(DEPTH):0]     o_LdWords,
    output logic                       o_LdError
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           ptr_q, ptr_d;
    logic [1:0]                 bidx_q, bidx_d;
    logic [DATA_IBUS_WIDTH-1:0] asm_q, asm_d;
    logic                       err_q, err_d;
    logic                       done_pend_q, done_pend_d;
    logic                       start_pend_q, start_pend_d;
    logic                       valid_q;

    logic                       byte_acc;
    logic                       start_now;
    logic                       ram_we;
    logic                       in_range;
    logic [IDX_W-1:0]           word_idx;
    logic [DATA_IBUS_WIDTH-1:0] ram_rdata;
    logic                       unused_addr_bits;

    assign o_LdReady = (state_q == StLoad) && !start_pend_q;
    assign o_Loading = (state_q == StLoad) || (state_q == StCommit);
    assign byte_acc  = i_LdValid && o_LdReady;
    // A start seen during COMMIT is latched and applied once the word write is done.
    assign start_now = (i_LdStart || start_pend_q) && (state_q != StCommit);
    assign ram_we    = (state_q == StCommit);

    assign word_idx         = i_PgmAddr[IDX_W+1:2];
    assign in_range         = (i_PgmAddr >> (IDX_W + 2)) == '0;
    assign unused_addr_bits = ^i_PgmAddr[1:0];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        bidx_d       = bidx_q;
        asm_d        = asm_q;
        err_d        = err_q;
        done_pend_d  = done_pend_q;
        start_pend_d = start_pend_q;

        unique case (state_q)
            StIdle: ;
            StLoad: begin
                if (byte_acc) begin
                    asm_d[{bidx_q, 3'b000} +: 8] = i_LdData;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        if (ptr_q == CNT_W'(DEPTH)) begin
                            // Overflow: drop the word, keep loading so the stream drains.
                            err_d = 1'b1;
                            if (i_LdDone) begin
                                state_d = StRun;
                            end
                        end else begin
                            state_d     = StCommit;
                            done_pend_d = i_LdDone;
                        end
                    end else if (i_LdDone) begin
                        err_d   = 1'b1;
                        bidx_d  = 2'd0;
                        state_d = StRun;
                    end
                end else if (i_LdDone) begin
                    if (bidx_q != 2'd0) begin
                        err_d = 1'b1;
                    end
                    bidx_d  = 2'd0;
                    state_d = StRun;
                end
            end
            StCommit: begin
                ptr_d        = ptr_q + 1'b1;
                start_pend_d = i_LdStart;
                done_pend_d  = 1'b0;
                state_d      = (done_pend_q && !i_LdStart) ? StRun : StLoad;
            end
            StRun: ;
            default: state_d = StIdle;
        endcase

        if (start_now) begin
            state_d      = StLoad;
            ptr_d        = '0;
            bidx_d       = 2'd0;
            err_d        = 1'b0;
            done_pend_d  = 1'b0;
            start_pend_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            bidx_q       <= 2'd0;
            asm_q        <= '0;
            err_q        <= 1'b0;
            done_pend_q  <= 1'b0;
            start_pend_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            bidx_q       <= bidx_d;
            asm_q        <= asm_d;
            err_q        <= err_d;
            done_pend_q  <= done_pend_d;
            start_pend_q <= start_pend_d;
            valid_q      <= (state_q == StRun) && in_range;
        end
    end

    ram_1r1w #(
        .WIDTH(DATA_IBUS_WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (i_Clock),
        .we   (ram_we),
        .waddr(ptr_q[IDX_W-1:0]),
        .wdata(asm_q),
        .raddr(word_idx),
        .rdata(ram_rdata)
    );

    assign o_PgmInst  = valid_q ? ram_rdata : INST_NOP;
    assign o_PgmValid = valid_q;
    assign o_LdWords  = ptr_q;
    assign o_LdError  = err_q;

endmodule

// File: doc/pgm_memory.md
# pgm_memory

Instruction-memory responder for the fetch stage: serves program words for the byte addresses the fetch stage issues, with one-cycle synchronous read latency. It also contains a byte-serial bootload port that assembles little-endian bytes into 32-bit words and writes them sequentially from address 0. A small state machine gates fetch responses so that the core sees only NOPs until a load session has completed.

## Interface
- DATA_IBUS_WIDTH, 32, instruction word width; fixed at 32.
- ADDR_IBUS_WIDTH, 32, fetch byte-address width.
- DEPTH, 1024, memory size in words; must be a power of 2, minimum 4.

- i_Clock  in  1  clock.
- i_Reset  in  1  reset; synchronous, active-low.
- i_PgmAddr  in  ADDR_IBUS_WIDTH  fetch byte address.
- o_PgmInst  out  DATA_IBUS_WIDTH  instruction for the address sampled at the previous edge.
- o_PgmValid  out  1  o_PgmInst comes from memory, not a forced NOP.
- i_LdStart  in  1  start a load session.
- i_LdValid  in  1  loader byte strobe.
- i_LdData  in  8  loader byte.
- o_LdReady  out  1  loader byte is accepted on an edge where i_LdValid && o_LdReady.
- i_LdDone  in  1  end the load session.
- o_Loading  out  1  high in LOAD or COMMIT.
- o_LdWords  out  $clog2(DEPTH)+1  words written this session.
- o_LdError  out  1  sticky flag: overflow or partial word at done.

## Operation
- States: IDLE (after reset), LOAD, COMMIT, RUN.
- IDLE
  - i_LdStart moves to LOAD.
  - Everything else is ignored.
- LOAD
  - o_LdReady = 1.
  - Each accepted byte fills the assembly register little-endian. Byte 0 goes to [7:0], byte 3 to [31:24].
  - The 4th byte goes to COMMIT.
- COMMIT (one cycle)
  - o_LdReady = 0.
  - Writes the word to mem[ptr], then ptr++ and o_LdWords++.
  - Returns to LOAD, or to RUN if a done is pending.
- Overflow
  - A word that completes while ptr == DEPTH is not written.
  - o_LdError is set, the state stays LOAD and ptr is not incremented.
- i_LdDone in LOAD
  - Byte index 0: go to RUN.
  - Byte index nonzero: discard the partial word, set o_LdError, go to RUN.
  - If a byte is accepted on the same edge: the byte counts first. If it completes a word, go to COMMIT with done pending, then RUN.
- i_LdStart in any state except COMMIT
  - Enters LOAD with ptr = 0, byte index = 0, o_LdWords = 0, o_LdError = 0.
  - Memory contents are not cleared.
  - It wins over a coincident i_LdDone.
- i_LdStart in COMMIT: deferred to the next cycle (the word write is never lost).
- Fetch address decode
  - Word index = i_PgmAddr[$clog2(DEPTH)+1:2].
  - Bits [1:0] are ignored (aligned read).
  - Any set bit above the index makes the address out of range.
- Fetch response
  - In RUN with an in-range address: o_PgmInst = mem[index] and o_PgmValid = 1 on the next edge.
  - In every other case: o_PgmInst = NOP (0x00000013) and o_PgmValid = 0.
- Reset
  - Memory is retained.
  - State is IDLE; ptr, byte index, o_LdWords and o_LdError are 0.
  - o_PgmInst = 0x00000013, o_PgmValid = 0, o_LdReady = 0, o_Loading = 0.
  - Reset in the middle of a load abandons the partial word and the session.

## Timing
- Fetch latency is 1 cycle from address to o_PgmInst. No bubbles: back-to-back addresses are served every cycle.
- All outputs are registered except o_LdReady and o_Loading, which are decoded from the state register.
- Loader throughput is 4 bytes per 5 cycles at full rate.
- Leaving COMMIT or LOAD for RUN: a fetch sampled in the first RUN cycle returns memory data one cycle later.
- A write and a read to the same word in the same cycle cannot occur, because reads are blocked outside RUN.

## Structure
- Package pgm_memory_pkg holds:
  - the state enum (IDLE, LOAD, COMMIT, RUN);
  - the constant INST_NOP = 32'h00000013.
- Sub-module ram_1r1w(WIDTH, DEPTH): synchronous read port and synchronous write port, no reset on the array.
- The top level holds the FSM, the assembly register, the pointer and address decode.

## Test plan
- Reset → o_PgmInst 0x00000013, o_PgmValid 0, o_LdReady 0, o_Loading 0, o_LdWords 0, o_LdError 0.
- Load and fetch
  - Stimulus: i_LdStart, then bytes 93 00 10 00 B7 12 00 00, then i_LdDone.
  - Required: o_LdWords 2, state RUN.
  - Address 0x0 → next cycle 0x00100093, valid 1. Address 0x4 → 0x000012B7. Address 0x6 → 0x000012B7.
- Full-rate byte stream → o_LdReady low exactly in the cycle after each 4th byte; a held byte is accepted on the following edge.
- DEPTH=4, load 5 words → o_LdWords 4, o_LdError 1, mem[0..3] intact.
- Partial word: 6 bytes then i_LdDone → o_LdWords 1, o_LdError 1, RUN.
  - i_LdDone coinciding with the 8th byte → o_LdWords 2, error 0.
- Reset after 2 loaded words → IDLE and fetch returns NOP/valid 0. A new load of 1 word then returns old word 1 at address 0x4.
- DEPTH=1024, fetch address 0x1000 → NOP, valid 0.
